// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the multicycle main controller.
// States, opcodes, aluop codes, pcsrc codes and ALU operand select codes.
package mc_pkg;

  // One state per step of the instruction sequencer (16 states, all encodings used)
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWR   = 4'd4,
    S_MEMWB   = 4'd5,
    S_LHUWB   = 4'd6,
    S_RTYPEEX = 4'd7,
    S_RTYPEWB = 4'd8,
    S_BEQEX   = 4'd9,
    S_BLTEX   = 4'd10,
    S_ADDIEX  = 4'd11,
    S_LIEX    = 4'd12,
    S_ITWB    = 4'd13,
    S_JEX     = 4'd14,
    S_ERR     = 4'd15
  } state_t;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_LHU  = 6'b100101;
  localparam logic [5:0] OP_BLT  = 6'b011101;
  localparam logic [5:0] OP_LI   = 6'b010001;

  // aluop codes sent to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OP    = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  // States that wait on the memory ready handshake
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: memory-wait cycle counter with synchronous clear and
// count enable. timeout is high while the count equals WAIT_MAX; the
// count saturates there until cleared.
module mc_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_MAX);

  logic [CW-1:0] count_r;

  assign timeout = (count_r == LIMIT);

  // Count waiting cycles; clear has priority, saturate at the limit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en && !timeout) begin
      count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle main controller for the MIPS-subset datapath.
// Moore FSM sequencing fetch/decode/execute/memory/writeback. The only
// input qualification of outputs is the memory handshake: the fetch strobes
// wait for mem_ready, and no write strobe is issued in the cycle where the
// wait timer has hit its limit. Outputs are forced low while reset is high.
// Optional feature: define MC_PERF_CNT_EN to add the 'retired' counter.
module mc_controller
  import mc_pkg::*;
#(
  parameter int WAIT_MAX = 15
`ifdef MC_PERF_CNT_EN
  ,
  parameter int PERF_W = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       branch,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal
`ifdef MC_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] retired
`endif
);

  state_t     state_r;
  state_t     state_next_s;
  logic       timeout_s;
  logic       wait_clr_s;
  logic       wait_en_s;

  logic       pcwrite_s;
  logic       branch_s;
  logic       iord_s;
  logic       memwrite_s;
  logic       irwrite_s;
  logic       regdst_s;
  logic       memtoreg_s;
  logic       regwrite_s;
  logic       alusrca_s;
  logic [1:0] alusrcb_s;
  logic [1:0] pcsrc_s;
  logic [1:0] aluop_s;
  logic       illegal_s;

  // Wait counter restarts on every state change, counts not-ready cycles
  assign wait_clr_s = (state_next_s != state_r);
  assign wait_en_s  = is_wait_state(state_r) && !mem_ready;

  mc_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (wait_clr_s),
    .en     (wait_en_s),
    .timeout(timeout_s)
  );

  // State register; reset returns to FETCH immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and output decode from the state register
  always_comb begin
    state_next_s = S_FETCH;
    pcwrite_s    = 1'b0;
    branch_s     = 1'b0;
    iord_s       = 1'b0;
    memwrite_s   = 1'b0;
    irwrite_s    = 1'b0;
    regdst_s     = 1'b0;
    memtoreg_s   = 1'b0;
    regwrite_s   = 1'b0;
    alusrca_s    = 1'b0;
    alusrcb_s    = SRCB_REG;
    pcsrc_s      = PCSRC_ALU;
    aluop_s      = ALUOP_ADD;
    illegal_s    = 1'b0;
    case (state_r)
      S_FETCH: begin
        alusrcb_s = SRCB_FOUR;
        if (timeout_s) begin
          state_next_s = S_ERR;
        end else if (mem_ready) begin
          irwrite_s    = 1'b1;
          pcwrite_s    = 1'b1;
          state_next_s = S_DECODE;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        alusrcb_s = SRCB_IMMSH2;
        case (op)
          OP_LW, OP_SW, OP_LHU: state_next_s = S_MEMADR;
          OP_R:                 state_next_s = S_RTYPEEX;
          OP_BEQ:               state_next_s = S_BEQEX;
          OP_BLT:               state_next_s = S_BLTEX;
          OP_ADDI:              state_next_s = S_ADDIEX;
          OP_LI:                state_next_s = S_LIEX;
          OP_J:                 state_next_s = S_JEX;
          default:              state_next_s = S_ERR;
        endcase
      end
      S_MEMADR: begin
        alusrca_s = 1'b1;
        alusrcb_s = SRCB_IMM;
        if (op == OP_SW) begin
          state_next_s = S_MEMWR;
        end else begin
          state_next_s = S_MEMRD;
        end
      end
      S_MEMRD: begin
        iord_s = 1'b1;
        if (timeout_s) begin
          state_next_s = S_ERR;
        end else if (mem_ready) begin
          state_next_s = (op == OP_LHU) ? S_LHUWB : S_MEMWB;
        end else begin
          state_next_s = S_MEMRD;
        end
      end
      S_MEMWR: begin
        iord_s = 1'b1;
        if (timeout_s) begin
          state_next_s = S_ERR;
        end else if (mem_ready) begin
          memwrite_s   = 1'b1;
          state_next_s = S_FETCH;
        end else begin
          memwrite_s   = 1'b1;
          state_next_s = S_MEMWR;
        end
      end
      S_MEMWB: begin
        memtoreg_s   = 1'b1;
        regwrite_s   = 1'b1;
        state_next_s = S_FETCH;
      end
      S_LHUWB: begin
        memtoreg_s   = 1'b1;
        regwrite_s   = 1'b1;
        aluop_s      = ALUOP_OP;
        state_next_s = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca_s    = 1'b1;
        aluop_s      = ALUOP_FUNCT;
        state_next_s = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst_s     = 1'b1;
        regwrite_s   = 1'b1;
        state_next_s = S_FETCH;
      end
      S_BEQEX: begin
        alusrca_s    = 1'b1;
        aluop_s      = ALUOP_SUB;
        branch_s     = 1'b1;
        pcsrc_s      = PCSRC_ALUOUT;
        state_next_s = S_FETCH;
      end
      S_BLTEX: begin
        alusrca_s    = 1'b1;
        aluop_s      = ALUOP_OP;
        branch_s     = 1'b1;
        pcsrc_s      = PCSRC_ALUOUT;
        state_next_s = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca_s    = 1'b1;
        alusrcb_s    = SRCB_IMM;
        state_next_s = S_ITWB;
      end
      S_LIEX: begin
        alusrca_s    = 1'b1;
        alusrcb_s    = SRCB_IMM;
        aluop_s      = ALUOP_OP;
        state_next_s = S_ITWB;
      end
      S_ITWB: begin
        regwrite_s   = 1'b1;
        state_next_s = S_FETCH;
      end
      S_JEX: begin
        pcwrite_s    = 1'b1;
        pcsrc_s      = PCSRC_JUMP;
        state_next_s = S_FETCH;
      end
      S_ERR: begin
        // PC already advanced in FETCH, so the bad instruction is skipped
        illegal_s    = 1'b1;
        state_next_s = S_FETCH;
      end
      default: begin
        state_next_s = S_FETCH;
      end
    endcase
  end

  // Hold every control low while reset is asserted
  assign pcwrite  = reset ? 1'b0  : pcwrite_s;
  assign branch   = reset ? 1'b0  : branch_s;
  assign iord     = reset ? 1'b0  : iord_s;
  assign memwrite = reset ? 1'b0  : memwrite_s;
  assign irwrite  = reset ? 1'b0  : irwrite_s;
  assign regdst   = reset ? 1'b0  : regdst_s;
  assign memtoreg = reset ? 1'b0  : memtoreg_s;
  assign regwrite = reset ? 1'b0  : regwrite_s;
  assign alusrca  = reset ? 1'b0  : alusrca_s;
  assign alusrcb  = reset ? 2'b00 : alusrcb_s;
  assign pcsrc    = reset ? 2'b00 : pcsrc_s;
  assign aluop    = reset ? 2'b00 : aluop_s;
  assign illegal  = reset ? 1'b0  : illegal_s;

`ifdef MC_PERF_CNT_EN
  logic          retire_s;
  logic [PERF_W-1:0] retired_r;

  // An instruction retires when a normal execution path returns to FETCH
  assign retire_s = (state_r != S_FETCH) && (state_r != S_ERR) &&
                    (state_next_s == S_FETCH);
  assign retired  = retired_r;

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_r <= '0;
    end else if (retire_s) begin
      retired_r <= retired_r + {{(PERF_W-1){1'b0}}, 1'b1};
    end else begin
      retired_r <= retired_r;
    end
  end
`endif

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed self-checking bench for mc_controller.
// Inputs change on the falling edge; outputs are compared 1 time unit later.
// Output vector order: pcwrite,branch,iord,memwrite,irwrite,regdst,memtoreg,
// regwrite,alusrca,alusrcb[1:0],pcsrc[1:0],aluop[1:0],illegal.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg;
  logic       regwrite, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc, aluop;
`ifdef MC_PERF_CNT_EN
  logic [31:0] retired;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] outs;
  assign outs = {pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg,
                 regwrite, alusrca, alusrcb, pcsrc, aluop, illegal};

  logic [15:0] e_fw, e_fr, e_dec, e_madr, e_mrd, e_mwr, e_mwb, e_lhuwb;
  logic [15:0] e_rex, e_rwb, e_beq, e_blt, e_addi, e_li, e_itwb, e_jex, e_err;

  mc_controller #(.WAIT_MAX(15)
`ifdef MC_PERF_CNT_EN
    , .PERF_W(32)
`endif
  ) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .branch(branch), .iord(iord), .memwrite(memwrite),
    .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .aluop(aluop), .illegal(illegal)
`ifdef MC_PERF_CNT_EN
    , .retired(retired)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ev(
    input logic pcw, br, io, mw, irw, rd, m2r, rw, asa,
    input logic [1:0] asb, pcs, aop,
    input logic ill);
    return {pcw, br, io, mw, irw, rd, m2r, rw, asa, asb, pcs, aop, ill};
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (outs !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", outs, 16'h0000);
    end
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (outs !== e_fw) begin
      n_fail++;
      $display("FAIL reset_fetch: got %h expected %h", outs, e_fw);
    end
    @(negedge clk);
  endtask

  task automatic test_lw();
    logic [15:0] ex [6];
    ex = '{e_fr, e_dec, e_madr, e_mrd, e_mwb, e_fr};
    apply_reset();
    op = 6'b100011;
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++;
      if (outs !== ex[i]) begin
        n_fail++;
        $display("FAIL lw cycle %0d: got %h expected %h", i, outs, ex[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sw_wait();
    logic [15:0] ex [8];
    logic        rdy [8];
    ex  = '{e_fr, e_dec, e_madr, e_mwr, e_mwr, e_mwr, e_mwr, e_fw};
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    apply_reset();
    op = 6'b101011;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i];
      #1;
      n_checks++;
      if (outs !== ex[i]) begin
        n_fail++;
        $display("FAIL sw cycle %0d: got %h expected %h", i, outs, ex[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lhu_wait();
    logic [15:0] ex [8];
    logic        rdy [8];
    ex  = '{e_fr, e_dec, e_madr, e_mrd, e_mrd, e_mrd, e_lhuwb, e_fw};
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    apply_reset();
    op = 6'b100101;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i];
      #1;
      n_checks++;
      if (outs !== ex[i]) begin
        n_fail++;
        $display("FAIL lhu cycle %0d: got %h expected %h", i, outs, ex[i]);
      end
      @(negedge clk);
    end
  endtask

  // Four-state instructions: FETCH, DECODE, one execute state, FETCH
  task automatic test_short_ops();
    logic [5:0]  ops [4];
    logic [15:0] exs [4];
    logic [15:0] ex  [4];
    ops = '{6'b011101, 6'b000100, 6'b000010, 6'b111111};
    exs = '{e_blt, e_beq, e_jex, e_err};
    for (int k = 0; k < 4; k++) begin
      apply_reset();
      op = ops[k];
      ex = '{e_fr, e_dec, exs[k], e_fw};
      for (int i = 0; i < 4; i++) begin
        mem_ready = (i == 0) ? 1'b1 : 1'b0;
        #1;
        n_checks++;
        if (outs !== ex[i]) begin
          n_fail++;
          $display("FAIL short op=%b cycle %0d: got %h expected %h",
                   ops[k], i, outs, ex[i]);
        end
        @(negedge clk);
      end
    end
  endtask

  // Five-state instructions with an execute and a writeback state
  task automatic test_long_ops();
    logic [5:0]  ops [3];
    logic [15:0] ex1 [3];
    logic [15:0] ex2 [3];
    logic [15:0] ex  [5];
    ops = '{6'b000000, 6'b001000, 6'b010001};
    ex1 = '{e_rex, e_addi, e_li};
    ex2 = '{e_rwb, e_itwb, e_itwb};
    for (int k = 0; k < 3; k++) begin
      apply_reset();
      op = ops[k];
      ex = '{e_fr, e_dec, ex1[k], ex2[k], e_fw};
      for (int i = 0; i < 5; i++) begin
        mem_ready = (i == 0) ? 1'b1 : 1'b0;
        #1;
        n_checks++;
        if (outs !== ex[i]) begin
          n_fail++;
          $display("FAIL long op=%b cycle %0d: got %h expected %h",
                   ops[k], i, outs, ex[i]);
        end
        @(negedge clk);
      end
    end
  endtask

  // 15 not-ready cycles, limit cycle ignores mem_ready, then ERR, then FETCH
  task automatic test_timeout();
    logic [15:0] exp_v;
    apply_reset();
    op = 6'b000000;
    for (int i = 0; i < 19; i++) begin
      mem_ready = (i == 15 || i == 18) ? 1'b1 : 1'b0;
      exp_v = (i == 16) ? e_err : ((i == 18) ? e_fr : e_fw);
      #1;
      n_checks++;
      if (outs !== exp_v) begin
        n_fail++;
        $display("FAIL timeout cycle %0d: got %h expected %h", i, outs, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    op = 6'b000000;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (outs !== e_rex) begin
      n_fail++;
      $display("FAIL mid_rex: got %h expected %h", outs, e_rex);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (outs !== 16'h0000) begin
      n_fail++;
      $display("FAIL mid_async_zero: got %h expected %h", outs, 16'h0000);
    end
    @(negedge clk);
    n_checks++;
    if (outs !== 16'h0000) begin
      n_fail++;
      $display("FAIL mid_held_zero: got %h expected %h", outs, 16'h0000);
    end
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (outs !== e_fr) begin
      n_fail++;
      $display("FAIL mid_refetch: got %h expected %h", outs, e_fr);
    end
    @(negedge clk);
  endtask

`ifdef MC_PERF_CNT_EN
  task automatic test_perf();
    logic [5:0] ops [3];
    int         len [3];
    ops = '{6'b000010, 6'b001000, 6'b111111};
    len = '{3, 4, 3};
    apply_reset();
    #1;
    n_checks++;
    if (retired !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_reset: got %0d expected %0d", retired, 0);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      op = ops[k];
      for (int i = 0; i < len[k]; i++) begin
        mem_ready = (i == 0) ? 1'b1 : 1'b0;
        @(negedge clk);
      end
    end
    #1;
    n_checks++;
    if (retired !== 32'd2) begin
      n_fail++;
      $display("FAIL perf_count: got %0d expected %0d", retired, 2);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    op = 6'b000000;
    mem_ready = 1'b0;
    e_fw    = ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0);
    e_fr    = ev(1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0);
    e_dec   = ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0);
    e_madr  = ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0);
    e_mrd   = ev(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0);
    e_mwr   = ev(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0);
    e_mwb   = ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0);
    e_lhuwb = ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b11,1'b0);
    e_rex   = ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b10,1'b0);
    e_rwb   = ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0);
    e_beq   = ev(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0);
    e_blt   = ev(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b11,1'b0);
    e_addi  = ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0);
    e_li    = ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b11,1'b0);
    e_itwb  = ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0);
    e_jex   = ev(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,1'b0);
    e_err   = ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1);

    test_reset();
    test_lw();
    test_sw_wait();
    test_lhu_wait();
    test_short_ops();
    test_long_ops();
    test_timeout();
    test_reset_mid();
`ifdef MC_PERF_CNT_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
